// File: rtl/pipeline_control_fsm_if.sv
// Hazard/memory/halt requests into the pipeline control FSM and the stage
// enables, flushes and status it returns.
interface pipeline_control_fsm_if #(
  parameter int CNT_W = 16
) ();
  logic             load_use_hazard;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             MEM_WB_Bubble;
  logic             halted;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output load_use_hazard, branch_taken, dmem_req, dmem_ready, halt_req, resume,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    input  IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, halted, mem_error, stall_cycles
  );

  modport slave (
    input  load_use_hazard, branch_taken, dmem_req, dmem_ready, halt_req, resume,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    output IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, halted, mem_error, stall_cycles
  );
endinterface

// File: rtl/pipeline_control_fsm.sv
// Pipeline stall/flush/halt controller with memory-wait timeout and a saturating stall counter.
// Control outputs are combinational (zero latency); a memory stall freezes every stage.
module pipeline_control_fsm #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_control_fsm_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, ERROR} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_stall;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              ex_mem_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              mem_wb_bubble;

  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    // Freeze has top priority: upstream stages keep their requests held.
    if (state_q == HALT || state_q == ERROR || mem_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bus.load_use_hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else if (bus.halt_req && !bus.branch_taken && !bus.load_use_hazard) begin
          state_d = HALT;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: begin
        if (bus.resume) begin
          state_d = RUN;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Only RUN/MEM_WAIT stalls are counted; HALT and ERROR freezes are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == RUN || state_q == MEM_WAIT) && !pc_write
                 && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.PC_Write      = pc_write;
  assign bus.IF_ID_Write   = if_id_write;
  assign bus.ID_EX_Write   = id_ex_write;
  assign bus.EX_MEM_Write  = ex_mem_write;
  assign bus.IF_ID_Flush   = if_id_flush;
  assign bus.ID_EX_Flush   = id_ex_flush;
  assign bus.MEM_WB_Bubble = mem_wb_bubble;
  assign bus.halted        = (state_q == HALT);
  assign bus.mem_error     = (state_q == ERROR);
  assign bus.stall_cycles  = cnt_q;

endmodule

// File: tb/tb_pipeline_control_fsm.sv
// Directed table-driven bench for pipeline_control_fsm (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_control_fsm_if #(.CNT_W(4)) bus ();

  pipeline_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // input codes {load_use, branch, dmem_req, dmem_ready, halt_req, resume}
  localparam logic [5:0] I_IDLE = 6'b000000;
  localparam logic [5:0] I_LU   = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_BRLU = 6'b110000;
  localparam logic [5:0] I_MSTL = 6'b001000;
  localparam logic [5:0] I_MDON = 6'b001100;
  localparam logic [5:0] I_HLT  = 6'b000010;
  localparam logic [5:0] I_RES  = 6'b000001;
  localparam logic [5:0] I_HR   = 6'b000011;
  localparam logic [5:0] I_HLU  = 6'b100010;
  localparam logic [5:0] I_MIX  = 6'b111010;

  // control codes {PC_W, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_Fl, ID_EX_Fl, MEM_WB_Bub}
  localparam logic [6:0] C_NORM = 7'b1111000;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BRF  = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0011010;

  typedef struct packed {
    logic       rst;
    logic [5:0] in;
    logic [6:0] ctrl;
    logic       hlt;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(input logic r, input logic [5:0] i, input logic [6:0] c,
                              input logic h, input logic e, input int n);
    vec_t t;
    t.rst  = r;
    t.in   = i;
    t.ctrl = c;
    t.hlt  = h;
    t.err  = e;
    t.cnt  = 4'(n);
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic [5:0] i);
    {bus.load_use_hazard, bus.branch_taken, bus.dmem_req,
     bus.dmem_ready, bus.halt_req, bus.resume} = i;
  endtask

  function automatic logic [6:0] ctrl_now();
    return {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Write, bus.EX_MEM_Write,
            bus.IF_ID_Flush, bus.ID_EX_Flush, bus.MEM_WB_Bubble};
  endfunction

  task automatic pulse_reset();
    drive(I_IDLE);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [6:0] c,
                           input logic h, input logic e, input int n);
    chk({tag, "_ctrl"}, idx, 32'(ctrl_now()), 32'(c));
    chk({tag, "_halted"}, idx, 32'(bus.halted), 32'(h));
    chk({tag, "_mem_error"}, idx, 32'(bus.mem_error), 32'(e));
    chk({tag, "_stall_cycles"}, idx, 32'(bus.stall_cycles), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // load-use, branch+load-use, stall overriding everything, exit
    vecs.push_back(mk(1, I_IDLE, C_NORM, 0, 0, 0));
    vecs.push_back(mk(0, I_LU,   C_LU,   0, 0, 0));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 1));
    vecs.push_back(mk(0, I_BRLU, C_BRF,  0, 0, 1));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 1));
    vecs.push_back(mk(0, I_BR,   C_BRF,  0, 0, 1));
    vecs.push_back(mk(0, I_MIX,  C_FRZ,  0, 0, 1));
    vecs.push_back(mk(0, I_MDON, C_NORM, 0, 0, 2));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 2));
    // memory wait of 3 cycles
    vecs.push_back(mk(1, I_MSTL, C_FRZ,  0, 0, 0));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 1));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 2));
    vecs.push_back(mk(0, I_MDON, C_NORM, 0, 0, 3));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 3));
    // MEM_WAIT exit cycle honours branch flush
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 3));
    vecs.push_back(mk(0, I_BR,   C_BRF,  0, 0, 4));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 4));
    // halt / resume
    vecs.push_back(mk(1, I_HLT,  C_NORM, 0, 0, 0));
    vecs.push_back(mk(0, I_IDLE, C_FRZ,  1, 0, 0));
    vecs.push_back(mk(0, I_LU,   C_FRZ,  1, 0, 0));
    vecs.push_back(mk(0, I_RES,  C_FRZ,  1, 0, 0));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 0));
    vecs.push_back(mk(0, I_HR,   C_NORM, 0, 0, 0));
    vecs.push_back(mk(0, I_IDLE, C_FRZ,  1, 0, 0));
    // halt_req together with load-use does not halt
    vecs.push_back(mk(1, I_HLU,  C_LU,   0, 0, 0));
    vecs.push_back(mk(0, I_IDLE, C_NORM, 0, 0, 1));
    // timeout: 5 freeze cycles then ERROR, which ignores ready/resume
    vecs.push_back(mk(1, I_MSTL, C_FRZ,  0, 0, 0));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 1));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 2));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 3));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 0, 4));
    vecs.push_back(mk(0, I_MSTL, C_FRZ,  0, 1, 5));
    vecs.push_back(mk(0, I_MDON, C_FRZ,  0, 1, 5));
    vecs.push_back(mk(0, I_RES,  C_FRZ,  0, 1, 5));
    vecs.push_back(mk(0, I_IDLE, C_FRZ,  0, 1, 5));

    drive(I_IDLE);
    #2;
    check_all("in_reset", 0, C_NORM, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].rst) pulse_reset();
      drive(vecs[k].in);
      #2;
      check_all("vec", k, vecs[k].ctrl, vecs[k].hlt, vecs[k].err, int'(vecs[k].cnt));
    end

    // asynchronous reset out of ERROR, mid-cycle
    @(negedge clk);
    drive(I_IDLE);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst_error", 0, C_NORM, 0, 0, 0);
    rst_n = 1'b1;

    // asynchronous reset out of MEM_WAIT
    @(negedge clk);
    drive(I_MSTL);
    @(negedge clk);
    @(negedge clk);
    #2;
    drive(I_IDLE);
    rst_n = 1'b0;
    #1;
    check_all("arst_memwait", 0, C_NORM, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_all("after_arst_memwait", 0, C_NORM, 0, 0, 0);

    // asynchronous reset out of HALT
    drive(I_HLT);
    @(negedge clk);
    drive(I_IDLE);
    #2;
    chk("halt_entered", 0, 32'(bus.halted), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all("arst_halt", 0, C_NORM, 0, 0, 0);
    rst_n = 1'b1;

    // saturation with load_use held for 20 cycles
    @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      drive(I_LU);
      #2;
      chk("sat_cnt", i, 32'(bus.stall_cycles), 32'((i < 15) ? i : 15));
    end
    @(negedge clk);
    drive(I_IDLE);
    #2;
    check_all("sat_final", 0, C_NORM, 0, 0, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
